// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the queue entry layout, the fetch FSM states and the instruction size.
package fetch_pkg;

    localparam int EntryBits = 32;
    localparam int InstrBytes = 4;
    localparam logic [31:0] NopInstr = 32'h0000_0013;

    typedef enum logic {
        FETCH_RUN,
        FETCH_HALT
    } fetch_state_e;

    typedef struct packed {
        logic [EntryBits-1:0] instr;
        logic [EntryBits-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch entries; head visible from the edge after push, no bypass.
// Producer must respect full (push while full only with a same-cycle pop); flush wins after pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  Depth   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  entry_t                     din,
    output entry_t                     head,
    output logic [$clog2(Depth+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PtrBits = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntBits = $clog2(Depth + 1);

    entry_t               mem_q [Depth];
    logic [PtrBits-1:0]   rd_ptr_q;
    logic [PtrBits-1:0]   wr_ptr_q;
    logic [CntBits-1:0]   count_q;

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrBits'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrBits'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntBits'(1);
                2'b01:   count_q <= count_q - CntBits'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CntBits'(Depth));
    assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, queues {word, pc} for decode; word valid 1 cycle after fetch.
// Decode stalls via instr_ready_i; a full queue freezes the PC; misaligned redirects halt fetch.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                 RegBits    = 32,
    parameter logic [RegBits-1:0] ResetPc    = '0,
    parameter int                 QueueDepth = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    output logic [RegBits-1:0] imem_addr_o,
    input  logic [RegBits-1:0] imem_data_i,
    input  logic               redirect_i,
    input  logic [RegBits-1:0] redirect_pc_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [RegBits-1:0] instr_o,
    output logic [RegBits-1:0] instr_pc_o,
    output logic [RegBits-1:0] instr_pc_plus4_o,
    output logic               misaligned_o
);

    typedef struct packed {
        logic [RegBits-1:0] instr;
        logic [RegBits-1:0] pc;
    } entry_t;

    fetch_state_e                      state_q;
    fetch_state_e                      state_d;
    logic [RegBits-1:0]                pc_q;
    logic                              misaligned_q;
    logic                              fetch_en;
    logic                              push;
    logic                              pop;
    logic                              q_full;
    logic                              q_empty;
    logic [$clog2(QueueDepth+1)-1:0]   unused_count;
    entry_t                            q_din;
    entry_t                            q_head;
    logic                              target_misaligned;

    assign target_misaligned = |redirect_pc_i[1:0];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= FETCH_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_i) begin
            state_d = target_misaligned ? FETCH_HALT : FETCH_RUN;
        end
    end

    always_comb begin
        fetch_en = (state_q == FETCH_RUN);
    end

    // A pop frees a slot in the same cycle, so a full queue can still accept.
    assign pop  = instr_valid_o & instr_ready_i;
    assign push = fetch_en & ~redirect_i & (~q_full | pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q         <= ResetPc;
            misaligned_q <= 1'b0;
        end else if (redirect_i) begin
            pc_q         <= redirect_pc_i;
            misaligned_q <= target_misaligned;
        end else if (push) begin
            pc_q         <= pc_q + RegBits'(InstrBytes);
        end
    end

    assign q_din.instr = imem_data_i;
    assign q_din.pc    = pc_q;

    fetch_queue #(
        .Depth   (QueueDepth),
        .entry_t (entry_t)
    ) u_queue (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .din   (q_din),
        .head  (q_head),
        .count (unused_count),
        .full  (q_full),
        .empty (q_empty)
    );

    assign imem_addr_o      = pc_q;
    assign instr_valid_o    = ~q_empty;
    assign instr_o          = q_head.instr;
    assign instr_pc_o       = q_head.pc;
    assign instr_pc_plus4_o = q_head.pc + RegBits'(InstrBytes);
    assign misaligned_o     = misaligned_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, random traffic against a queue model,
// and a wrap-around run on a second instance with a high reset PC.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: ResetPc = 0
    logic        rst0_n, redir0, ready0;
    logic [31:0] rpc0, addr0, data0, instr0, ipc0, ipc4_0;
    logic        valid0, mis0;

    // Instance 1: ResetPc near the top of the address space
    logic        rst1_n, redir1, ready1;
    logic [31:0] rpc1, addr1, data1, instr1, ipc1, ipc4_1;
    logic        valid1, mis1;

    assign data0 = 32'h00A00093 + addr0;
    assign data1 = 32'h00A00093 + addr1;

    fetch_stage #(.RegBits(32), .ResetPc(32'h0000_0000), .QueueDepth(2)) u0 (
        .clk_i(clk), .rst_ni(rst0_n), .imem_addr_o(addr0), .imem_data_i(data0),
        .redirect_i(redir0), .redirect_pc_i(rpc0), .instr_valid_o(valid0),
        .instr_ready_i(ready0), .instr_o(instr0), .instr_pc_o(ipc0),
        .instr_pc_plus4_o(ipc4_0), .misaligned_o(mis0)
    );

    fetch_stage #(.RegBits(32), .ResetPc(32'hFFFF_FFF8), .QueueDepth(2)) u1 (
        .clk_i(clk), .rst_ni(rst1_n), .imem_addr_o(addr1), .imem_data_i(data1),
        .redirect_i(redir1), .redirect_pc_i(rpc1), .instr_valid_o(valid1),
        .instr_ready_i(ready1), .instr_o(instr1), .instr_pc_o(ipc1),
        .instr_pc_plus4_o(ipc4_1), .misaligned_o(mis1)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of fetched entries plus the fetch PC.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ment_t;

    ment_t       mq[$];
    logic [31:0] m_pc;
    bit          m_halt;
    bit          m_mis;
    bit          m_ok = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h00A00093 + a;
    endfunction

    task automatic model_check();
        if (!m_ok) return;
        check("model_valid", {31'b0, valid0}, {31'b0, (mq.size() > 0)});
        if (mq.size() > 0) begin
            check("model_instr", instr0, mq[0].instr);
            check("model_pc", ipc0, mq[0].pc);
            check("model_pc4", ipc4_0, mq[0].pc + 32'd4);
        end
        check("model_addr", addr0, m_pc);
        check("model_mis", {31'b0, mis0}, {31'b0, m_mis});
    endtask

    task automatic model_edge();
        int  sz;
        bit  did_pop;
        if (!rst0_n) begin
            mq.delete();
            m_pc   = 32'h0;
            m_halt = 0;
            m_mis  = 0;
            m_ok   = 1;
        end else if (m_ok) begin
            sz      = mq.size();
            did_pop = (sz > 0) && ready0;
            if (did_pop) void'(mq.pop_front());
            if (redir0) begin
                mq.delete();
                m_pc   = rpc0;
                m_halt = (rpc0[1:0] != 2'b00);
                m_mis  = m_halt;
            end else if (!m_halt && (sz < 2 || did_pop)) begin
                mq.push_back('{instr: word_at(m_pc), pc: m_pc});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // Called just after a negedge: apply inputs, settle, check against the model.
    task automatic drive(input logic r, input logic d, input logic [31:0] p, input logic y);
        rst0_n = r;
        redir0 = d;
        rpc0   = p;
        ready0 = y;
        #1;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    typedef struct {
        logic        rst_n;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        bit          chk;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
        logic        emis;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic d, input logic [31:0] p, input logic y,
                       input bit c, input logic v, input logic [31:0] epc,
                       input logic [31:0] ea, input logic em);
        vq.push_back('{rst_n: r, redir: d, rpc: p, ready: y, chk: c,
                       ev: v, epc: epc, eaddr: ea, emis: em});
    endtask

    logic [31:0] exp5_pc [3];
    logic [31:0] exp5_p4 [3];
    logic [31:0] rpc_r;

    initial begin
        rst0_n = 0; redir0 = 0; rpc0 = 0; ready0 = 0;
        rst1_n = 0; redir1 = 0; rpc1 = 0; ready1 = 0;

        // Reset, then free-running fetch with decode always ready
        add(0,0,0,1, 0, 0,32'h0,32'h0,0);
        add(0,0,0,1, 1, 0,32'h0,32'h0,0);
        add(1,0,0,1, 1, 0,32'h0,32'h0,0);
        add(1,0,0,1, 1, 1,32'h0,32'h4,0);
        add(1,0,0,1, 1, 1,32'h4,32'h8,0);
        add(1,0,0,1, 1, 1,32'h8,32'hC,0);
        add(1,0,0,1, 1, 1,32'hC,32'h10,0);
        // Decode stalled for 5 cycles from reset: queue fills, PC parks at 8
        add(0,0,0,0, 1, 1,32'h10,32'h14,0);
        add(1,0,0,0, 1, 0,32'h0,32'h0,0);
        add(1,0,0,0, 1, 1,32'h0,32'h4,0);
        for (int i = 0; i < 3; i++) add(1,0,0,0, 1, 1,32'h0,32'h8,0);
        add(1,0,0,1, 1, 1,32'h0,32'h8,0);
        add(1,0,0,1, 1, 1,32'h4,32'hC,0);
        add(1,0,0,1, 1, 1,32'h8,32'h10,0);
        // Redirect while full with a same-cycle pop
        add(0,0,0,0, 1, 1,32'hC,32'h14,0);
        add(1,0,0,0, 1, 0,32'h0,32'h0,0);
        add(1,0,0,0, 1, 1,32'h0,32'h4,0);
        add(1,1,32'h100,1, 1, 1,32'h0,32'h8,0);
        add(1,0,0,1, 1, 0,32'h0,32'h100,0);
        add(1,0,0,1, 1, 1,32'h100,32'h104,0);
        // Misaligned redirect halts fetch; aligned redirect recovers
        add(1,1,32'h102,1, 1, 1,32'h104,32'h108,0);
        for (int i = 0; i < 10; i++) add(1,0,0,1, 1, 0,32'h0,32'h102,1);
        add(1,1,32'h200,1, 1, 0,32'h0,32'h102,1);
        add(1,0,0,1, 1, 0,32'h0,32'h200,0);
        add(1,0,0,1, 1, 1,32'h200,32'h204,0);
        // Reset with a full queue and a concurrent misaligned redirect
        add(1,0,0,0, 1, 1,32'h204,32'h208,0);
        add(1,0,0,0, 1, 1,32'h204,32'h20C,0);
        add(0,1,32'h302,1, 1, 1,32'h204,32'h20C,0);
        add(1,0,0,0, 1, 0,32'h0,32'h0,0);

        @(negedge clk);
        foreach (vq[i]) begin
            drive(vq[i].rst_n, vq[i].redir, vq[i].rpc, vq[i].ready);
            if (vq[i].chk) begin
                check($sformatf("vec%0d_valid", i), {31'b0, valid0}, {31'b0, vq[i].ev});
                if (vq[i].ev) begin
                    check($sformatf("vec%0d_pc", i), ipc0, vq[i].epc);
                    check($sformatf("vec%0d_instr", i), instr0, word_at(vq[i].epc));
                    check($sformatf("vec%0d_pc4", i), ipc4_0, vq[i].epc + 32'd4);
                end
                check($sformatf("vec%0d_addr", i), addr0, vq[i].eaddr);
                check($sformatf("vec%0d_mis", i), {31'b0, mis0}, {31'b0, vq[i].emis});
            end
            tick();
        end

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rpc_r = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) rpc_r[1:0] = 2'($urandom_range(1, 3));
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 19) == 0),
                  rpc_r,
                  ($urandom_range(0, 9) < 7));
            tick();
        end

        // Wrap-around of the PC at the top of the address space
        exp5_pc[0] = 32'hFFFF_FFF8; exp5_p4[0] = 32'hFFFF_FFFC;
        exp5_pc[1] = 32'hFFFF_FFFC; exp5_p4[1] = 32'h0000_0000;
        exp5_pc[2] = 32'h0000_0000; exp5_p4[2] = 32'h0000_0004;
        rst1_n = 0; ready1 = 1;
        @(posedge clk);
        @(negedge clk);
        rst1_n = 1;
        #1;
        check("wrap_reset_valid", {31'b0, valid1}, 32'h0);
        check("wrap_reset_addr", addr1, 32'hFFFF_FFF8);
        check("wrap_reset_mis", {31'b0, mis1}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            check($sformatf("wrap%0d_valid", i), {31'b0, valid1}, 32'h1);
            check($sformatf("wrap%0d_pc", i), ipc1, exp5_pc[i]);
            check($sformatf("wrap%0d_instr", i), instr1, word_at(exp5_pc[i]));
            check($sformatf("wrap%0d_pc4", i), ipc4_1, exp5_p4[i]);
            check($sformatf("wrap%0d_addr", i), addr1, exp5_p4[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage directly upstream of the combinational byte-addressed instruction memory. It owns the program counter and drives the word address to the memory. It captures the returned 32-bit word, with its PC, into a small queue and presents it to decode over a valid/ready handshake. It also accepts branch/jump redirects from execute and flags misaligned redirect targets.

Parameters:
RegBits, 32, width of PC, address and instruction word
ResetPc, 32'h0000_0000, PC value loaded on reset
QueueDepth, 2, instruction queue entries (power of two, >= 2)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_ni  in  1  synchronous active-low reset
imem_addr_o  out  RegBits  byte address to instruction memory, equals pc_q (combinational)
imem_data_i  in  RegBits  little-endian instruction word returned same cycle for imem_addr_o
redirect_i  in  1  execute requests PC change this cycle
redirect_pc_i  in  RegBits  redirect target byte address
instr_valid_o  out  1  queue head holds a valid instruction
instr_ready_i  in  1  decode accepts head this cycle
instr_o  out  RegBits  head instruction word
instr_pc_o  out  RegBits  PC of head instruction
instr_pc_plus4_o  out  RegBits  instr_pc_o + 4, modulo 2^RegBits
misaligned_o  out  1  sticky: last redirect target had [1:0] != 0

Behaviour:
- Reset (rst_ni=0 at clock edge): pc_q=ResetPc, queue count=0, read/write pointers=0, state=RUN, misaligned_o=0. Therefore instr_valid_o=0. instr_o, instr_pc_o and instr_pc_plus4_o are don't-care while invalid. Reset overrides redirect and all handshakes; reset mid-operation discards queued entries.
- imem_addr_o = pc_q at all times. The memory is combinational, so imem_data_i is valid in the same cycle.
- pop = instr_valid_o & instr_ready_i. A pop is a completed transfer, including in a redirect cycle.
- push = (state==RUN) & !redirect_i & (count<QueueDepth | pop). On push: entry {imem_data_i, pc_q} is written at the tail, and pc_q <= pc_q + 4 (wraps at 2^RegBits, no flag).
- Simultaneous push and pop when full or non-empty: count is unchanged and both pointers advance. Pointers wrap mod QueueDepth.
- Full with no pop: no push, pc_q holds, and imem_addr_o is stable.
- Empty: instr_valid_o=0 and pop is impossible. There is no bypass path, so fetch-to-decode latency is 1 cycle minimum (push at edge N, valid from N).
- Redirect (redirect_i=1, priority over push): the queue is cleared at the edge (count=0, pointers=0) after any same-cycle pop. Then:
  - If redirect_pc_i[1:0]==0: pc_q <= redirect_pc_i, state=RUN, misaligned_o <= 0.
  - Else: pc_q <= redirect_pc_i, state=HALT, misaligned_o <= 1.
- States:
  - RUN: normal fetch.
  - HALT: no pushes and pc_q frozen; the queue drains to empty (already empty after the redirect). Leaves HALT only on an aligned redirect (to RUN) or on reset. A misaligned redirect while in HALT stays in HALT.
- The first instruction after a redirect at edge N is pushed at edge N+1 and becomes valid from N+1.
- instr_pc_plus4_o is computed combinationally from the head PC, RegBits wide, with carry discarded.

Decomposition:
- Package fetch_pkg:
  - fetch_entry_t packed struct {instr[RegBits-1:0], pc[RegBits-1:0]}
  - fetch_state_e {FETCH_RUN, FETCH_HALT}
  - InstrBytes=4
  - NopInstr=32'h0000_0013 (bench filler)
- One sub-module, fetch_queue: a parameterised circular FIFO of fetch_entry_t.
  - Inputs: push, pop, flush, data in.
  - Outputs: head, count, full, empty.
  - Synchronous active-low reset.
  - Flush takes effect after the same-cycle pop.
- fetch_stage holds pc_q, the FSM, the push/redirect logic and the output adders.

Test Plan:
1. Reset then run, ready=1, memory word at address A = 32'h00A00093+A: sequential outputs show pc 0,4,8,12 with matching words; valid rises the cycle after reset release.
2. ready=0 for 5 cycles from reset: exactly 2 pushes, pc_q=8 and held, imem_addr_o=8 stable. Then ready=1: pc 0 then 4 delivered, no gap, fetch resumes at 8.
3. Redirect to 32'h0000_0100 while queue full and ready=1: head pc 0 is consumed that cycle, queue is empty next cycle, and the next valid has pc 0x100 with its word. Entry pc 4 is never presented.
4. Redirect to 32'h0000_0102: misaligned_o=1 next cycle, instr_valid_o stays 0 for 10 cycles, imem_addr_o=0x102 frozen. Then redirect to 0x200: misaligned_o=0, and pc 0x200 is delivered.
5. ResetPc=32'hFFFF_FFF8, ready=1: pcs FFFF_FFF8, FFFF_FFFC, 0000_0000; instr_pc_plus4_o for FFFF_FFFC equals 0.
6. Assert rst_ni=0 for one cycle with a full queue and a concurrent redirect: next cycle valid=0, pc_q=ResetPc, misaligned_o=0, and the redirect is ignored.
